// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the benches
// that check the "110" detector against its stream.
package seq_tx_pkg;

   localparam int ST_IDLE  = 0;
   localparam int ST_SHIFT = 1;
   localparam int ST_GAP   = 2;

   typedef logic [2:0] state_t;

   localparam logic [2:0] S_IDLE  = 3'b001;
   localparam logic [2:0] S_SHIFT = 3'b010;
   localparam logic [2:0] S_GAP   = 3'b100;

endpackage

// File: rtl/seq110_ref.sv
// Reference counter: counts "110" runs in a bit stream, saturating, with
// a clear that also wipes the two-bit history.
module seq110_ref
   import seq_tx_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [1:0]       hist_q, hist_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      hist_d = {hist_q[0], bit_in};
      cnt_d  = cnt_q;
      if (clr) begin
         hist_d = '0;
         cnt_d  = '0;
      end else if ((hist_q == 2'b11) && !bit_in && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         cnt_q  <= '0;
      end else begin
         hist_q <= hist_d;
         cnt_q  <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/seq_tx.sv
// Parallel-to-serial transmitter: shifts a word out MSB-first, then holds
// the line low for GAP cycles; a reference counter tracks emitted "110"s.
module seq_tx
   import seq_tx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int GAP   = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_sig,
   output logic             busy,
   output logic             word_done,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] exp_cnt
);

   localparam int BC_W = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
   logic [3:0]       gapcnt_q, gapcnt_d;
   logic             out_q, out_d;

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
      gapcnt_d = gapcnt_q;
      out_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               out_d    = in_data[WIDTH-1];
               shift_d  = in_data << 1;
               bitcnt_d = BC_W'(WIDTH - 1);
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (bitcnt_q != '0) begin
               out_d    = shift_q[WIDTH-1];
               shift_d  = shift_q << 1;
               bitcnt_d = bitcnt_q - BC_W'(1);
            end else begin
               gapcnt_d = 4'(GAP - 1);
               state_d  = S_GAP;
            end
         end
         S_GAP: begin
            if (gapcnt_q == '0) state_d = S_IDLE;
            else                gapcnt_d = gapcnt_q - 4'd1;
         end
         // Any non-one-hot encoding falls back to IDLE.
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         bitcnt_q <= '0;
         gapcnt_q <= '0;
         out_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bitcnt_q <= bitcnt_d;
         gapcnt_q <= gapcnt_d;
         out_q    <= out_d;
      end
   end

   assign out_sig   = out_q;
   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_SHIFT) || (state_q == S_GAP);
   assign word_done = (state_q == S_SHIFT) && (bitcnt_q == '0);

   seq110_ref #(.CNT_W(CNT_W)) u_ref (
      .clk    (clk),
      .rst_n  (rst_n),
      .bit_in (out_q),
      .clr    (cnt_clr),
      .cnt    (exp_cnt)
   );

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: directed words, scoreboard of transmitted bits and
// reference counts, plus cycle-exact waveform and handshake checks.
module tb_seq_tx;

   localparam int W  = 8;
   localparam int G  = 2;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          cnt_clr = 1'b0;
   logic          in_ready, out_sig, busy, word_done;
   logic [CW-1:0] exp_cnt;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [W-1:0]  mon_sh = '0;
   logic          mon_pend = 1'b0;
   logic [CW-1:0] mon_cnt = '0;
   exp_t          mon_e;

   seq_tx #(.WIDTH(W), .GAP(G), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_sig   (out_sig),
      .busy      (busy),
      .word_done (word_done),
      .cnt_clr   (cnt_clr),
      .exp_cnt   (exp_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int g = 0;
      while (!in_ready && g < 200) begin
         tick();
         g++;
      end
      check("idle_ready", 32'(in_ready), 32'd1);
   endtask

   // Returns one time unit after the accepting edge (first bit on the line).
   task automatic accept(input logic [W-1:0] d, input logic [CW-1:0] c);
      exp_t e;
      wait_idle();
      e.data = d;
      e.cnt  = c;
      in_valid = 1'b1;
      in_data  = d;
      exp_q.push_back(e);
      tick();
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic pulse_clr();
      wait_idle();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr_cnt", 32'(exp_cnt), 32'd0);
   endtask

   // Monitor: collects the serial bits and scores each finished word.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_pend = 1'b0;
            mon_sh   = '0;
         end else begin
            mon_sh = {mon_sh[W-2:0], out_sig};
            if (word_done) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL sb_unexpected: got word %0h expected none", mon_sh);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("sb_bits", 32'(mon_sh), 32'(mon_e.data));
                  mon_pend = 1'b1;
                  mon_cnt  = mon_e.cnt;
               end
            end else if (mon_pend && in_ready) begin
               check("sb_cnt", 32'(exp_cnt), 32'(mon_cnt));
               mon_pend = 1'b0;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [9:0]   pat;
      logic [W-1:0] words [3];
      logic [CW-1:0] wcnt [3];
      int k;
      int last;

      // Reset behaviour
      #12;
      check("rst_out", 32'(out_sig), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cnt", 32'(exp_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_quiet", 32'({out_sig, in_ready, busy, word_done, exp_cnt}), 32'b010000);
      end

      // Single word D0, cycle exact
      pat = 10'b1101000000;
      accept(8'hD0, 2'd1);
      for (int i = 0; i < 10; i++) begin
         check("d0_out", 32'(out_sig), 32'(pat[9-i]));
         check("d0_done", 32'(word_done), 32'(i == 7));
         check("d0_cnt", 32'(exp_cnt), 32'(i >= 3));
         check("d0_ready", 32'(in_ready), 32'd0);
         tick();
      end
      check("d0_ready_back", 32'(in_ready), 32'd1);

      // Boundary crossings
      pulse_clr();
      accept(8'hFF, 2'd1);
      for (int i = 0; i < 10; i++) begin
         check("ff_cnt_gap", 32'(exp_cnt), 32'(i >= 9));
         tick();
      end
      accept(8'h01, 2'd1);
      accept(8'h03, 2'd2);
      accept(8'h80, 2'd2);

      // Handshake: valid held, data churning while busy
      pulse_clr();
      wait_idle();
      words[0] = 8'hA5; wcnt[0] = 2'd0;
      words[1] = 8'h5A; wcnt[1] = 2'd1;
      words[2] = 8'h3C; wcnt[2] = 2'd2;
      k = 0;
      last = 0;
      in_valid = 1'b1;
      for (int c = 0; c < 23; c++) begin
         if (in_ready && k < 3) begin
            exp_t e;
            e.data = words[k];
            e.cnt  = wcnt[k];
            in_data = words[k];
            exp_q.push_back(e);
            if (k > 0) check("accept_spacing", 32'(c - last), 32'(W + G + 1));
            last = c;
            k++;
         end else begin
            in_data = 8'hE7 ^ 8'(c);
         end
         tick();
      end
      in_valid = 1'b0;
      in_data  = '0;
      check("accept_count", 32'(k), 32'd3);

      // Reset in the middle of a word
      accept(8'hFF, 2'd0);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_out", 32'(out_sig), 32'd0);
      check("mrst_cnt", 32'(exp_cnt), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_done", 32'(word_done), 32'd0);
      check("mrst_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      accept(8'hC0, 2'd1);

      // Saturation and clear
      pulse_clr();
      accept(8'hC0, 2'd1);
      accept(8'hC0, 2'd2);
      accept(8'hC0, 2'd3);
      accept(8'hC0, 2'd3);
      pulse_clr();
      accept(8'hC0, 2'd1);

      wait_idle();
      for (int i = 0; i < 4; i++) tick();
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
